// File: rtl/fpu_align_pkg.sv
// Shared types and constants for the FPU operand-alignment unit.
package fpu_align_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] DISC_A_GT = 2'b10;
    localparam logic [1:0] DISC_A_LT = 2'b00;
    localparam logic [1:0] DISC_EQ   = 2'b11;

    localparam int unsigned GRS_BITS = 3;

endpackage

// File: rtl/sticky_shift_step.sv
// One alignment step: right shift by 0..STEP bits, folding every bit lost
// off the bottom into bit 0 so the sticky bit survives iteration.
module sticky_shift_step #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned STEP  = 4,
    parameter int unsigned AW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    amount,
    output logic [WIDTH-1:0] data_out
);

    logic lost;

    always_comb begin
        lost = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (i < 32'(amount)) begin
                lost = lost | data_in[i];
            end
        end
        data_out    = data_in >> amount;
        data_out[0] = data_out[0] | lost;
    end

endmodule

// File: rtl/exponent_align.sv
// Handshaked operand alignment: picks the larger-magnitude operand and
// iteratively right-shifts the smaller mantissa with guard/round/sticky.
module exponent_align
    import fpu_align_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MAN_WIDTH  = 24,
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [EXP_WIDTH-1:0]          exp_a,
    input  logic [EXP_WIDTH-1:0]          exp_b,
    input  logic [MAN_WIDTH-1:0]          man_a,
    input  logic [MAN_WIDTH-1:0]          man_b,
    input  logic                          sign_a,
    input  logic                          sign_b,
    input  logic                          op_sub,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EXP_WIDTH-1:0]          exp_out,
    output logic [EXP_WIDTH-1:0]          exp_diff,
    output logic [1:0]                    exp_disc,
    output logic [MAN_WIDTH-1:0]          man_big,
    output logic [MAN_WIDTH+GRS_BITS-1:0] man_small_aligned,
    output logic                          sign_big,
    output logic                          swap,
    output logic                          eff_sub
);

    localparam int unsigned SR_W = MAN_WIDTH + GRS_BITS;
    localparam int unsigned SAT  = SR_W;
    localparam int unsigned RW   = $clog2(SAT + 1);
    localparam int unsigned KW   = $clog2(SHIFT_STEP + 1);

    state_t                state_q, state_d;
    logic [SR_W-1:0]       sreg_q, sreg_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [EXP_WIDTH-1:0]  exp_out_q, exp_out_d;
    logic [EXP_WIDTH-1:0]  exp_diff_q, exp_diff_d;
    logic [1:0]            exp_disc_q, exp_disc_d;
    logic [MAN_WIDTH-1:0]  man_big_q, man_big_d;
    logic                  sign_big_q, sign_big_d;
    logic                  swap_q, swap_d;
    logic                  eff_sub_q, eff_sub_d;

    logic                  b_exp_gt;
    logic                  swap_c;
    logic                  sign_b_eff;
    logic [EXP_WIDTH-1:0]  diff_c;
    logic [RW-1:0]         sh_c;
    logic [KW-1:0]         k_c;
    logic [SR_W-1:0]       shifted_c;

    sticky_shift_step #(
        .WIDTH (SR_W),
        .STEP  (SHIFT_STEP),
        .AW    (KW)
    ) u_step (
        .data_in  (sreg_q),
        .amount   (k_c),
        .data_out (shifted_c)
    );

    always_comb begin
        b_exp_gt   = exp_b > exp_a;
        swap_c     = b_exp_gt | ((exp_a == exp_b) & (man_b > man_a));
        sign_b_eff = sign_b ^ op_sub;
        diff_c     = b_exp_gt ? (exp_b - exp_a) : (exp_a - exp_b);
        // Saturate on the full-width difference; never truncate it first.
        if (32'(diff_c) >= SAT) begin
            sh_c = RW'(SAT);
        end else begin
            sh_c = RW'(diff_c);
        end
        if (32'(rem_q) < SHIFT_STEP) begin
            k_c = KW'(rem_q);
        end else begin
            k_c = KW'(SHIFT_STEP);
        end

        state_d    = state_q;
        sreg_d     = sreg_q;
        rem_d      = rem_q;
        exp_out_d  = exp_out_q;
        exp_diff_d = exp_diff_q;
        exp_disc_d = exp_disc_q;
        man_big_d  = man_big_q;
        sign_big_d = sign_big_q;
        swap_d     = swap_q;
        eff_sub_d  = eff_sub_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_out_d  = b_exp_gt ? exp_b : exp_a;
                    exp_diff_d = diff_c;
                    if (exp_a == exp_b) begin
                        exp_disc_d = DISC_EQ;
                    end else if (b_exp_gt) begin
                        exp_disc_d = DISC_A_LT;
                    end else begin
                        exp_disc_d = DISC_A_GT;
                    end
                    man_big_d  = swap_c ? man_b : man_a;
                    sign_big_d = swap_c ? sign_b_eff : sign_a;
                    swap_d     = swap_c;
                    eff_sub_d  = sign_a ^ sign_b_eff;
                    sreg_d     = {(swap_c ? man_a : man_b), {GRS_BITS{1'b0}}};
                    rem_d      = sh_c;
                    state_d    = (sh_c == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = shifted_c;
                rem_d  = rem_q - RW'(k_c);
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            rem_q      <= '0;
            exp_out_q  <= '0;
            exp_diff_q <= '0;
            exp_disc_q <= '0;
            man_big_q  <= '0;
            sign_big_q <= 1'b0;
            swap_q     <= 1'b0;
            eff_sub_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            rem_q      <= rem_d;
            exp_out_q  <= exp_out_d;
            exp_diff_q <= exp_diff_d;
            exp_disc_q <= exp_disc_d;
            man_big_q  <= man_big_d;
            sign_big_q <= sign_big_d;
            swap_q     <= swap_d;
            eff_sub_q  <= eff_sub_d;
        end
    end

    assign in_ready          = (state_q == IDLE);
    assign out_valid         = (state_q == DONE);
    assign exp_out           = exp_out_q;
    assign exp_diff          = exp_diff_q;
    assign exp_disc          = exp_disc_q;
    assign man_big           = man_big_q;
    assign man_small_aligned = sreg_q;
    assign sign_big          = sign_big_q;
    assign swap              = swap_q;
    assign eff_sub           = eff_sub_q;

endmodule

// File: tb/tb_exponent_align.sv
// Directed self-checking bench for exponent_align (EXP 8, MAN 24, STEP 4).
module tb_exponent_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  exp_a = '0, exp_b = '0;
    logic [23:0] man_a = '0, man_b = '0;
    logic        sign_a = 1'b0, sign_b = 1'b0, op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  exp_out, exp_diff;
    logic [1:0]  exp_disc;
    logic [23:0] man_big;
    logic [26:0] msa;
    logic        sign_big, swap, eff_sub;

    int checks = 0;
    int failures = 0;
    int lat;

    exponent_align #(
        .EXP_WIDTH  (8),
        .MAN_WIDTH  (24),
        .SHIFT_STEP (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .exp_a             (exp_a),
        .exp_b             (exp_b),
        .man_a             (man_a),
        .man_b             (man_b),
        .sign_a            (sign_a),
        .sign_b            (sign_b),
        .op_sub            (op_sub),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .exp_out           (exp_out),
        .exp_diff          (exp_diff),
        .exp_disc          (exp_disc),
        .man_big           (man_big),
        .man_small_aligned (msa),
        .sign_big          (sign_big),
        .swap              (swap),
        .eff_sub           (eff_sub)
    );

    always #5 clk = ~clk;

    // Drives one operand pair and counts edges from accept to out_valid (bounded).
    task automatic launch(input logic [7:0] ea, input logic [7:0] eb,
                          input logic [23:0] ma, input logic [23:0] mb,
                          input logic sa, input logic sb, input logic sub,
                          output int latency);
        exp_a = ea; exp_b = eb; man_a = ma; man_b = mb;
        sign_a = sa; sign_b = sb; op_sub = sub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        latency = 1;
        while (out_valid !== 1'b1 && latency < 40) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if ({exp_out, exp_diff, exp_disc, man_big, msa, sign_big, swap, eff_sub} !== '0)
            begin failures++; $display("FAIL reset_data got exp_out=%0d diff=%0d msa=%h", exp_out, exp_diff, msa); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_a_larger();
        launch(8'd130, 8'd127, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL agt_latency got=%0d exp=2", lat); end
        checks++; if (exp_disc !== 2'b10) begin failures++; $display("FAIL agt_disc got=%b exp=10", exp_disc); end
        checks++; if (exp_out !== 8'd130) begin failures++; $display("FAIL agt_exp_out got=%0d exp=130", exp_out); end
        checks++; if (exp_diff !== 8'd3) begin failures++; $display("FAIL agt_exp_diff got=%0d exp=3", exp_diff); end
        checks++; if (msa !== 27'h0C00000) begin failures++; $display("FAIL agt_msa got=%h exp=0c00000", msa); end
        checks++; if ({swap, eff_sub, sign_big} !== 3'b000) begin failures++; $display("FAIL agt_flags got=%b exp=000", {swap, eff_sub, sign_big}); end
        checks++; if (man_big !== 24'h800000) begin failures++; $display("FAIL agt_man_big got=%h exp=800000", man_big); end
        handoff();
    endtask

    task automatic test_saturate();
        launch(8'd100, 8'd140, 24'h800001, 24'hC00000, 1'b0, 1'b0, 1'b0, lat);
        checks++; if (lat !== 8) begin failures++; $display("FAIL sat_latency got=%0d exp=8", lat); end
        checks++; if (exp_diff !== 8'd40) begin failures++; $display("FAIL sat_exp_diff got=%0d exp=40", exp_diff); end
        checks++; if (msa !== 27'h0000001) begin failures++; $display("FAIL sat_msa got=%h exp=0000001", msa); end
        checks++; if (swap !== 1'b1) begin failures++; $display("FAIL sat_swap got=%b exp=1", swap); end
        checks++; if (exp_disc !== 2'b00) begin failures++; $display("FAIL sat_disc got=%b exp=00", exp_disc); end
        checks++; if (exp_out !== 8'd140) begin failures++; $display("FAIL sat_exp_out got=%0d exp=140", exp_out); end
        checks++; if (man_big !== 24'hC00000) begin failures++; $display("FAIL sat_man_big got=%h exp=c00000", man_big); end
        handoff();
    endtask

    task automatic test_sticky();
        launch(8'd10, 8'd5, 24'h800000, 24'h800001, 1'b0, 1'b0, 1'b0, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL sticky_latency got=%0d exp=3", lat); end
        checks++; if (msa !== 27'h0200001) begin failures++; $display("FAIL sticky_msa got=%h exp=0200001", msa); end
        handoff();
    endtask

    task automatic test_equal_exp();
        launch(8'd127, 8'd127, 24'h900000, 24'hA00000, 1'b0, 1'b1, 1'b0, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL eq_latency got=%0d exp=1", lat); end
        checks++; if (exp_disc !== 2'b11) begin failures++; $display("FAIL eq_disc got=%b exp=11", exp_disc); end
        checks++; if ({swap, sign_big, eff_sub} !== 3'b111) begin failures++; $display("FAIL eq_flags got=%b exp=111", {swap, sign_big, eff_sub}); end
        checks++; if (man_big !== 24'hA00000) begin failures++; $display("FAIL eq_man_big got=%h exp=a00000", man_big); end
        checks++; if (msa !== 27'h4800000) begin failures++; $display("FAIL eq_msa got=%h exp=4800000", msa); end
        handoff();
        launch(8'd90, 8'd90, 24'h123456, 24'h123456, 1'b1, 1'b0, 1'b0, lat);
        checks++; if ({swap, sign_big, exp_disc} !== 4'b0111) begin failures++; $display("FAIL eqmag_flags got=%b exp=0111", {swap, sign_big, exp_disc}); end
        checks++; if (msa !== 27'h091A2B0) begin failures++; $display("FAIL eqmag_msa got=%h exp=091a2b0", msa); end
        handoff();
    endtask

    task automatic test_eff_sub();
        launch(8'd128, 8'd120, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b1, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL effsub_latency got=%0d exp=3", lat); end
        checks++; if ({eff_sub, sign_big, swap} !== 3'b100) begin failures++; $display("FAIL effsub_flags got=%b exp=100", {eff_sub, sign_big, swap}); end
        checks++; if (msa !== 27'h0040000) begin failures++; $display("FAIL effsub_msa got=%h exp=0040000", msa); end
        handoff();
    endtask

    task automatic test_hold();
        launch(8'd130, 8'd127, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            exp_a = 8'(50 + i);
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL hold_hs cyc=%0d got=%b exp=10", i, {out_valid, in_ready}); end
            checks++; if (exp_out !== 8'd130 || msa !== 27'h0C00000 || exp_diff !== 8'd3)
                begin failures++; $display("FAIL hold_data cyc=%0d got exp_out=%0d diff=%0d msa=%h exp 130/3/0c00000", i, exp_out, exp_diff, msa); end
        end
        in_valid = 1'b0;
        handoff();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b exp=01", {out_valid, in_ready}); end
        checks++; if (exp_out !== 8'd130) begin failures++; $display("FAIL hold_no_accept got=%0d exp=130", exp_out); end
    endtask

    task automatic test_reset_mid_shift();
        bit seen_valid;
        exp_a = 8'd150; exp_b = 8'd130; man_a = 24'h800000; man_b = 24'h800000;
        sign_a = 1'b0; sign_b = 1'b0; op_sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL rstmid_hs got=%b exp=01", {out_valid, in_ready}); end
        checks++; if ({exp_out, exp_diff, exp_disc, man_big, msa, sign_big, swap, eff_sub} !== '0)
            begin failures++; $display("FAIL rstmid_data got exp_out=%0d diff=%0d msa=%h exp all 0", exp_out, exp_diff, msa); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_valid got=%b exp=0", seen_valid); end
        launch(8'd130, 8'd127, 24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, lat);
        checks++; if (lat !== 2 || msa !== 27'h0C00000) begin failures++; $display("FAIL rstmid_next got lat=%0d msa=%h exp 2/0c00000", lat, msa); end
        handoff();
    endtask

    initial begin
        test_reset();
        test_a_larger();
        test_saturate();
        test_sticky();
        test_equal_exp();
        test_eff_sub();
        test_hold();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
